// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the phase-1 control unit: FSM states, IR opcodes,
// ALU op_code values and instruction field positions.
package cpu_ctrl_pkg;

    localparam int unsigned STATE_W   = 4;
    localparam int unsigned OPC_W     = 5;
    localparam int unsigned REG_IDX_W = 4;

    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned RA_LSB  = 23;
    localparam int unsigned RB_LSB  = 19;
    localparam int unsigned RC_LSB  = 15;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T1W  = 4'd3,
        S_T2   = 4'd4,
        S_T3   = 4'd5,
        S_T4   = 4'd6,
        S_T5   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam logic [OPC_W-1:0] OPC_ADD = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_SUB = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_OR  = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_AND = 5'b00110;

    localparam logic [OPC_W-1:0] ALU_NOP = 5'b00000;
    localparam logic [OPC_W-1:0] ALU_OR  = 5'b00001;
    localparam logic [OPC_W-1:0] ALU_AND = 5'b00010;
    localparam logic [OPC_W-1:0] ALU_ADD = 5'b00011;
    localparam logic [OPC_W-1:0] ALU_SUB = 5'b00100;

    function automatic logic opc_legal(input logic [OPC_W-1:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_OR) || (opc == OPC_AND);
    endfunction

    function automatic logic [OPC_W-1:0] alu_op(input logic [OPC_W-1:0] opc);
        logic [OPC_W-1:0] op;
        case (opc)
            OPC_ADD: op = ALU_ADD;
            OPC_SUB: op = ALU_SUB;
            OPC_OR:  op = ALU_OR;
            OPC_AND: op = ALU_AND;
            default: op = ALU_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/reg_select_decode.sv
// Register index plus enable to one-hot register strobe vector.
module reg_select_decode #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned IDX_W    = 4
) (
    input  logic [IDX_W-1:0]    i_idx,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot
);

    assign o_onehot = i_en ? (NUM_REGS'(1) << i_idx) : '0;

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) then three-register ALU execute (T3-T5).
// Control outputs are decoded from the registered state plus the IR fields.
module alu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned IR_W     = 32
) (
    input  logic                 Clock,
    input  logic                 Clear,
    input  logic                 Run_en,
    input  logic                 Mem_ready,
    input  logic [IR_W-1:0]      IR,
    output logic                 PCout,
    output logic                 Zlowout,
    output logic                 MDRout,
    output logic                 MARin,
    output logic                 PCin,
    output logic                 MDRin,
    output logic                 IRin,
    output logic                 Yin,
    output logic                 ZLowIn,
    output logic                 IncPC,
    output logic                 Read,
    output logic [OPC_W-1:0]     op_code,
    output logic [NUM_REGS-1:0]  Rin,
    output logic [NUM_REGS-1:0]  Rout,
    output logic                 Run,
    output logic [STATE_W-1:0]   Present_state
);

    state_t               r_state;
    logic [OPC_W-1:0]     w_opc;
    logic [REG_IDX_W-1:0] w_ra;
    logic [REG_IDX_W-1:0] w_rb;
    logic [REG_IDX_W-1:0] w_rc;
    logic                 w_legal;
    logic [REG_IDX_W-1:0] w_rout_idx;
    logic                 w_rout_en;
    logic                 w_rin_en;
    logic                 w_ir_unused;

    assign w_opc       = IR[OPC_LSB +: OPC_W];
    assign w_ra        = IR[RA_LSB +: REG_IDX_W];
    assign w_rb        = IR[RB_LSB +: REG_IDX_W];
    assign w_rc        = IR[RC_LSB +: REG_IDX_W];
    assign w_legal     = opc_legal(w_opc);
    assign w_ir_unused = ^IR;

    // Clear wins over every transition; memory wait in T1W has no timeout.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:       if (Run_en) r_state <= S_T0;
                S_T0:         r_state <= S_T1;
                S_T1, S_T1W:  r_state <= Mem_ready ? S_T2 : S_T1W;
                S_T2:         r_state <= S_T3;
                S_T3:         r_state <= w_legal ? S_T4 : S_HALT;
                S_T4:         r_state <= S_T5;
                S_T5:         r_state <= Run_en ? S_T0 : S_IDLE;
                S_HALT:       r_state <= S_HALT;
                default:      r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        MARin   = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        ZLowIn  = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        op_code = ALU_NOP;
        case (r_state)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                ZLowIn = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T1W: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3:    Yin = w_legal;
            S_T4: begin
                ZLowIn  = 1'b1;
                op_code = alu_op(w_opc);
            end
            S_T5:    Zlowout = 1'b1;
            default: ;
        endcase
    end

    // Rout selects Rb in T3 and Rc in T4; Rin selects Ra in T5.
    assign w_rout_idx = (r_state == S_T4) ? w_rc : w_rb;
    assign w_rout_en  = ((r_state == S_T3) && w_legal) || (r_state == S_T4);
    assign w_rin_en   = (r_state == S_T5);

    reg_select_decode #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (REG_IDX_W)
    ) u_rout_dec (
        .i_idx    (w_rout_idx),
        .i_en     (w_rout_en),
        .o_onehot (Rout)
    );

    reg_select_decode #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (REG_IDX_W)
    ) u_rin_dec (
        .i_idx    (w_ra),
        .i_en     (w_rin_en),
        .o_onehot (Rin)
    );

    assign Run           = (r_state != S_IDLE) && (r_state != S_HALT);
    assign Present_state = STATE_W'(r_state);

endmodule
